// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle; PIPE_CTRL_PERF_EN adds perf counters
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rs1_id, rs2_id;
  logic                  use_rs1_id, use_rs2_id;
  logic                  valid_id, halt_id;
  logic                  valid_ex, RWrEn_ex, is_load_ex;
  logic [REG_ADDR_W-1:0] Rdst_ex;
  logic                  take_branch_ex;
  logic                  valid_mem, RWrEn_mem;
  logic [REG_ADDR_W-1:0] Rdst_mem;
  logic                  valid_wb, RWrEn_wb, halt_wb;
  logic [REG_ADDR_W-1:0] Rdst_wb;
  logic                  mem_busy;

  logic                  pc_wen;
  logic                  wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb;
  logic                  kill_if, kill_id;
  logic [1:0]            fwd_a, fwd_b;
  logic                  mem_timeout;
  logic                  halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]           stall_cycles;
  logic [31:0]           flush_count;
`endif

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, valid_id, halt_id,
           valid_ex, RWrEn_ex, is_load_ex, Rdst_ex, take_branch_ex,
           valid_mem, RWrEn_mem, Rdst_mem, valid_wb, RWrEn_wb, halt_wb, Rdst_wb,
           mem_busy,
    input  pc_wen, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb,
           kill_if, kill_id, fwd_a, fwd_b, mem_timeout, halted
`ifdef PIPE_CTRL_PERF_EN
           , stall_cycles, flush_count
`endif
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, valid_id, halt_id,
           valid_ex, RWrEn_ex, is_load_ex, Rdst_ex, take_branch_ex,
           valid_mem, RWrEn_mem, Rdst_mem, valid_wb, RWrEn_wb, halt_wb, Rdst_wb,
           mem_busy,
    output pc_wen, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb,
           kill_if, kill_id, fwd_a, fwd_b, mem_timeout, halted
`ifdef PIPE_CTRL_PERF_EN
           , stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline hazard/halt controller; PIPE_CTRL_PERF_EN adds stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             load_use;
  logic             flush_evt, stall_evt;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  use_rs,
    input logic                  mem_wr,
    input logic [REG_ADDR_W-1:0] mem_dst,
    input logic                  wb_wr,
    input logic [REG_ADDR_W-1:0] wb_dst
  );
    if (use_rs && (rs != '0) && mem_wr && (mem_dst == rs)) return 2'b01;
    if (use_rs && (rs != '0) && wb_wr && (wb_dst == rs))   return 2'b10;
    return 2'b00;
  endfunction

  assign load_use = hz.valid_ex && hz.is_load_ex && hz.RWrEn_ex && (hz.Rdst_ex != '0) &&
                    ((hz.use_rs1_id && (hz.rs1_id == hz.Rdst_ex)) ||
                     (hz.use_rs2_id && (hz.rs2_id == hz.Rdst_ex)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (hz.halt_id && hz.valid_id && !hz.take_branch_ex && !hz.mem_busy)
                  state_d = ST_DRAIN;
      ST_DRAIN: if (hz.halt_wb) state_d = ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  // Counter saturates at the threshold; the sticky flag sets on the edge it gets there.
  always_comb begin
    busy_cnt_d = '0;
    if (hz.mem_busy) busy_cnt_d = (busy_cnt_q == CNT_MAX) ? busy_cnt_q : busy_cnt_q + 1'b1;
    mem_timeout_d = mem_timeout_q || (busy_cnt_d == CNT_MAX);
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_RUN;
      busy_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_cnt_q    <= busy_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Outputs are gated by RST directly so they are forced while reset is held, independent of inputs.
  always_comb begin
    hz.pc_wen     = 1'b1;
    hz.wen_if_id  = 1'b0;
    hz.wen_id_ex  = 1'b0;
    hz.wen_ex_mem = 1'b0;
    hz.wen_mem_wb = 1'b0;
    hz.kill_if    = 1'b0;
    hz.kill_id    = 1'b0;
    hz.halted     = 1'b0;
    hz.fwd_a      = 2'b00;
    hz.fwd_b      = 2'b00;
    flush_evt     = 1'b0;
    stall_evt     = 1'b0;
    if (RST) begin
      hz.fwd_a = fwd_sel(hz.rs1_id, hz.use_rs1_id, hz.valid_mem && hz.RWrEn_mem, hz.Rdst_mem,
                         hz.valid_wb && hz.RWrEn_wb, hz.Rdst_wb);
      hz.fwd_b = fwd_sel(hz.rs2_id, hz.use_rs2_id, hz.valid_mem && hz.RWrEn_mem, hz.Rdst_mem,
                         hz.valid_wb && hz.RWrEn_wb, hz.Rdst_wb);
      if (state_q == ST_HALTED) begin
        hz.pc_wen     = 1'b0;
        hz.wen_if_id  = 1'b1;
        hz.wen_id_ex  = 1'b1;
        hz.wen_ex_mem = 1'b1;
        hz.wen_mem_wb = 1'b1;
        hz.halted     = 1'b1;
      end else begin
        if (hz.mem_busy) begin
          hz.pc_wen     = 1'b0;
          hz.wen_if_id  = 1'b1;
          hz.wen_id_ex  = 1'b1;
          hz.wen_ex_mem = 1'b1;
          hz.wen_mem_wb = 1'b1;
        end else if (hz.take_branch_ex) begin
          hz.kill_if = 1'b1;
          hz.kill_id = 1'b1;
          flush_evt  = 1'b1;
        end else if (load_use) begin
          hz.pc_wen    = 1'b0;
          hz.wen_if_id = 1'b1;
          hz.kill_id   = 1'b1;
        end
        // Draining: fetch stops and IF keeps injecting bubbles while older work retires.
        if (state_q == ST_DRAIN) begin
          hz.pc_wen  = 1'b0;
          hz.kill_if = 1'b1;
        end
        stall_evt = !hz.pc_wen;
      end
    end
  end

  assign hz.mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_evt && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_evt && (flush_count_q != '1))  flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`else
  logic unused_perf;
  assign unused_perf = stall_evt ^ flush_evt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl against a rule-level model
module tb_pipeline_hazard_ctrl;
  localparam int TO = 4;

  logic CLK;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz();

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(TO)) dut (
    .CLK(CLK),
    .RST(RST),
    .hz (hz)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  bit m_draining, m_halted, m_timeout;
  int m_busy_run;

  // {pc_wen, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb, kill_if, kill_id, fwd_a, fwd_b, mem_timeout, halted}
  function automatic logic [12:0] pk(bit pc, bit wif, bit wie, bit wem, bit wmw, bit kif, bit kid,
                                     logic [1:0] fa, logic [1:0] fb, bit to, bit h);
    return {pc, wif, wie, wem, wmw, kif, kid, fa, fb, to, h};
  endfunction

  function automatic logic [12:0] obs();
    return {hz.pc_wen, hz.wen_if_id, hz.wen_id_ex, hz.wen_ex_mem, hz.wen_mem_wb,
            hz.kill_if, hz.kill_id, hz.fwd_a, hz.fwd_b, hz.mem_timeout, hz.halted};
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] rs, logic use_rs);
    if (rs == 0 || !use_rs) return 2'b00;
    if (hz.valid_mem && hz.RWrEn_mem && hz.Rdst_mem == rs) return 2'b01;
    if (hz.valid_wb && hz.RWrEn_wb && hz.Rdst_wb == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [12:0] model_out();
    bit lu, pc, wif, wall, kif, kid;
    logic [1:0] fa, fb;
    if (!RST) return pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    fa = ref_fwd(hz.rs1_id, hz.use_rs1_id);
    fb = ref_fwd(hz.rs2_id, hz.use_rs2_id);
    if (m_halted) return pk(0, 1, 1, 1, 1, 0, 0, fa, fb, m_timeout, 1);
    lu = hz.valid_ex && hz.is_load_ex && hz.RWrEn_ex && hz.Rdst_ex != 0 &&
         ((hz.use_rs1_id && hz.rs1_id == hz.Rdst_ex) || (hz.use_rs2_id && hz.rs2_id == hz.Rdst_ex));
    pc = 1; wif = 0; wall = 0; kif = 0; kid = 0;
    if (hz.mem_busy) begin pc = 0; wif = 1; wall = 1; end
    else if (hz.take_branch_ex) begin kif = 1; kid = 1; end
    else if (lu) begin pc = 0; wif = 1; kid = 1; end
    if (m_draining) begin pc = 0; kif = 1; end
    return pk(pc, wif, wall, wall, wall, kif, kid, fa, fb, m_timeout, 0);
  endfunction

  task automatic model_update();
    if (!RST) begin
      m_draining = 0; m_halted = 0; m_timeout = 0; m_busy_run = 0;
    end else begin
      if (m_draining && hz.halt_wb) begin m_draining = 0; m_halted = 1; end
      else if (!m_draining && !m_halted && hz.halt_id && hz.valid_id && !hz.take_branch_ex && !hz.mem_busy)
        m_draining = 1;
      m_busy_run = hz.mem_busy ? ((m_busy_run < 1000) ? m_busy_run + 1 : m_busy_run) : 0;
      if (m_busy_run >= TO) m_timeout = 1;
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    hz.rs1_id = 0; hz.rs2_id = 0; hz.use_rs1_id = 0; hz.use_rs2_id = 0;
    hz.valid_id = 0; hz.halt_id = 0; hz.valid_ex = 0; hz.RWrEn_ex = 0; hz.is_load_ex = 0;
    hz.Rdst_ex = 0; hz.take_branch_ex = 0; hz.valid_mem = 0; hz.RWrEn_mem = 0; hz.Rdst_mem = 0;
    hz.valid_wb = 0; hz.RWrEn_wb = 0; hz.halt_wb = 0; hz.Rdst_wb = 0; hz.mem_busy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 0;
    tick();
    RST = 1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    clear_inputs();
    hz.mem_busy = 1; hz.take_branch_ex = 1; hz.halt_id = 1; hz.valid_id = 1;
    RST = 0;
    #1;
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_forced: got %b expected %b", obs(), e); end
    tick();
    clear_inputs();
    RST = 1;
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_run: got %b expected %b", obs(), e); end
    tick();
    // enter DRAIN, freeze with mem_busy, then assert reset asynchronously
    hz.halt_id = 1; hz.valid_id = 1;
    tick();
    clear_inputs();
    hz.mem_busy = 1;
    @(posedge CLK);
    e = pk(0, 1, 1, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL drain_busy: got %b expected %b", obs(), e); end
    #1;
    RST = 0;
    #1;
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_in_drain: got %b expected %b", obs(), e); end
    tick();
    RST = 1;
    clear_inputs();
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL run_after_reset: got %b expected %b", obs(), e); end
    tick();
  endtask

  task automatic test_load_use();
    logic [12:0] e;
    do_reset();
    hz.valid_ex = 1; hz.is_load_ex = 1; hz.RWrEn_ex = 1; hz.Rdst_ex = 5;
    hz.valid_id = 1; hz.rs1_id = 5; hz.use_rs1_id = 1;
    @(posedge CLK);
    e = pk(0, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL load_use_bubble: got %b expected %b", obs(), e); end
    tick();
    hz.valid_ex = 0; hz.is_load_ex = 0; hz.RWrEn_ex = 0; hz.Rdst_ex = 0;
    hz.valid_wb = 1; hz.RWrEn_wb = 1; hz.Rdst_wb = 5;
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL load_use_after: got %b expected %b", obs(), e); end
    tick();
    clear_inputs();
    hz.valid_ex = 1; hz.is_load_ex = 1; hz.RWrEn_ex = 1; hz.Rdst_ex = 0;
    hz.valid_id = 1; hz.rs1_id = 0; hz.use_rs1_id = 1;
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL load_x0_no_stall: got %b expected %b", obs(), e); end
    tick();
  endtask

  task automatic test_branch_priority();
    logic [12:0] e;
    do_reset();
    hz.valid_ex = 1; hz.is_load_ex = 1; hz.RWrEn_ex = 1; hz.Rdst_ex = 3;
    hz.valid_id = 1; hz.rs2_id = 3; hz.use_rs2_id = 1; hz.take_branch_ex = 1;
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL branch_over_loaduse: got %b expected %b", obs(), e); end
    tick();
    clear_inputs();
    hz.halt_id = 1; hz.valid_id = 1; hz.take_branch_ex = 1;
    tick();
    clear_inputs();
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL branch_flushes_halt: got %b expected %b", obs(), e); end
    tick();
  endtask

  task automatic test_mem_busy();
    logic [12:0] e;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall0;
`endif
    do_reset();
`ifdef PIPE_CTRL_PERF_EN
    stall0 = hz.stall_cycles;
`endif
    for (int i = 0; i < 3; i++) begin
      hz.mem_busy = 1; hz.take_branch_ex = 1;
      @(posedge CLK);
      e = pk(0, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL busy_freeze_%0d: got %b expected %b", i, obs(), e); end
      tick();
    end
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (hz.stall_cycles !== stall0 + 32'd3) begin
      n_fail++; $display("FAIL perf_stall: got %0d expected %0d", hz.stall_cycles, stall0 + 32'd3);
    end
`endif
    hz.mem_busy = 0;
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL busy_release_branch: got %b expected %b", obs(), e); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      hz.mem_busy = 1;
      @(posedge CLK);
      n_checks++;
      if (hz.mem_timeout !== ((i - 1) >= TO)) begin
        n_fail++; $display("FAIL timeout_edge_%0d: got %b expected %b", i - 1, hz.mem_timeout, (i - 1) >= TO);
      end
      tick();
    end
    hz.mem_busy = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      n_checks++;
      if (hz.mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", hz.mem_timeout); end
      tick();
    end
    do_reset();
    @(posedge CLK);
    n_checks++;
    if (hz.mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_reset: got %b expected 0", hz.mem_timeout); end
    tick();
    for (int i = 0; i < TO - 1; i++) begin hz.mem_busy = 1; tick(); hz.mem_busy = 0; tick(); end
    @(posedge CLK);
    n_checks++;
    if (hz.mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_nonconsec: got %b expected 0", hz.mem_timeout); end
    tick();
  endtask

  task automatic test_halt();
    logic [12:0] e;
    do_reset();
    hz.halt_id = 1; hz.valid_id = 1;
    @(posedge CLK);
    e = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL halt_in_run: got %b expected %b", obs(), e); end
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      hz.halt_wb = (i == 2);
      @(posedge CLK);
      e = pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL drain_cycle_%0d: got %b expected %b", i, obs(), e); end
      tick();
    end
    clear_inputs();
    hz.take_branch_ex = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      e = pk(0, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL halted_%0d: got %b expected %b", i, obs(), e); end
      tick();
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    hz.rs1_id = 0; hz.use_rs1_id = 1; hz.valid_mem = 1; hz.RWrEn_mem = 1; hz.Rdst_mem = 0;
    hz.rs2_id = 7; hz.use_rs2_id = 1;
    hz.valid_wb = 1; hz.RWrEn_wb = 1; hz.Rdst_wb = 7;
    @(posedge CLK);
    n_checks++;
    if (hz.fwd_a !== 2'b00 || hz.fwd_b !== 2'b10) begin
      n_fail++; $display("FAIL fwd_x0_wb: got %b/%b expected 00/10", hz.fwd_a, hz.fwd_b);
    end
    tick();
    hz.Rdst_mem = 7;
    @(posedge CLK);
    n_checks++;
    if (hz.fwd_b !== 2'b01) begin n_fail++; $display("FAIL fwd_mem_beats_wb: got %b expected 01", hz.fwd_b); end
    tick();
    hz.use_rs2_id = 0;
    @(posedge CLK);
    n_checks++;
    if (hz.fwd_b !== 2'b00) begin n_fail++; $display("FAIL fwd_unused: got %b expected 00", hz.fwd_b); end
    tick();
  endtask

  task automatic test_random();
    logic [12:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      hz.rs1_id = 5'($urandom_range(0, 3)); hz.rs2_id = 5'($urandom_range(0, 3));
      hz.use_rs1_id = 1'($urandom); hz.use_rs2_id = 1'($urandom);
      hz.valid_id = 1'($urandom); hz.halt_id = ($urandom_range(0, 9) == 0);
      hz.valid_ex = 1'($urandom); hz.RWrEn_ex = 1'($urandom); hz.is_load_ex = 1'($urandom);
      hz.Rdst_ex = 5'($urandom_range(0, 3)); hz.take_branch_ex = ($urandom_range(0, 4) == 0);
      hz.valid_mem = 1'($urandom); hz.RWrEn_mem = 1'($urandom); hz.Rdst_mem = 5'($urandom_range(0, 3));
      hz.valid_wb = 1'($urandom); hz.RWrEn_wb = 1'($urandom); hz.Rdst_wb = 5'($urandom_range(0, 3));
      hz.halt_wb = ($urandom_range(0, 5) == 0);
      hz.mem_busy = ($urandom_range(0, 3) == 0);
      RST = ($urandom_range(0, 39) != 0);
      @(posedge CLK);
      e = model_out();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL random_%0d: got %b expected %b", i, obs(), e); end
      tick();
    end
  endtask

  initial begin
    RST = 0;
    m_draining = 0; m_halted = 0; m_timeout = 0; m_busy_run = 0;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_busy();
    test_timeout();
    test_halt();
    test_forwarding();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
